// File: rtl/lcd_page_sched_pkg.sv
// Shared definitions for the LCD page scheduler and the LCD writer:
// page codes, scheduler states, request vector layout and priority ranking.
package lcd_page_sched_pkg;

    localparam logic [2:0] PG_CLOCK = 3'd0;
    localparam logic [2:0] PG_EDIT  = 3'd1;
    localparam logic [2:0] PG_MENU  = 3'd2;
    localparam logic [2:0] PG_PROG  = 3'd3;
    localparam logic [2:0] PG_OVER  = 3'd4;
    localparam logic [2:0] PG_RING  = 3'd5;
    localparam logic [2:0] PG_TOAST = 3'd6;
    localparam logic [2:0] PG_BLANK = 3'd7;

    typedef enum logic [1:0] {
        WAIT_INIT,
        ISSUE,
        BUSY,
        ABORT
    } sched_state_t;

    typedef struct packed {
        logic ring;
        logic over;
        logic toast;
        logic prog;
        logic edit;
        logic menu;
    } page_req_t;

    // BLANK is the off-phase of a blinking RING page, so it ranks with RING.
    function automatic logic [2:0] page_rank(input logic [2:0] pg);
        case (pg)
            PG_CLOCK: page_rank = 3'd0;
            PG_MENU:  page_rank = 3'd1;
            PG_EDIT:  page_rank = 3'd2;
            PG_PROG:  page_rank = 3'd3;
            PG_TOAST: page_rank = 3'd4;
            PG_OVER:  page_rank = 3'd5;
            default:  page_rank = 3'd6;
        endcase
    endfunction

    function automatic logic is_ring_group(input logic [2:0] pg);
        return (pg == PG_RING) || (pg == PG_BLANK);
    endfunction

endpackage

// File: rtl/lcd_page_prio.sv
// Combinational priority encoder: active page requests to the winning page
// code and its rank. CLOCK wins when nothing else is requested.
module lcd_page_prio
    import lcd_page_sched_pkg::*;
(
    input  logic [5:0] req,
    output logic [2:0] winner,
    output logic [2:0] rank
);

    page_req_t r;
    assign r = req;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        winner = PG_CLOCK;
        if (r.ring)       winner = PG_RING;
        else if (r.over)  winner = PG_OVER;
        else if (r.toast) winner = PG_TOAST;
        else if (r.prog)  winner = PG_PROG;
        else if (r.edit)  winner = PG_EDIT;
        else if (r.menu)  winner = PG_MENU;
        rank = page_rank(winner);
    end

endmodule

// File: rtl/lcd_page_sched.sv
// Page scheduler for the LCD writer: picks the page per frame, preempts for
// alarms, shows a confirmation toast. Optional RING blink: LCD_SCHED_BLINK_EN.
module lcd_page_sched
    import lcd_page_sched_pkg::*;
#(
    parameter int MIN_DWELL    = 2,
    parameter int TOAST_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_done,
    input  logic       ring_req,
    input  logic       over_req,
    input  logic       prog_req,
    input  logic       edit_req,
    input  logic       menu_req,
    input  logic       commit,
    input  logic       frame_done,
    output logic [2:0] page,
    output logic       start,
    output logic       abort,
    output logic       busy
);

    localparam int DW_W = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);
    localparam int TC_W = (TOAST_FRAMES < 1) ? 1 : $clog2(TOAST_FRAMES + 1);

    sched_state_t    state, state_nx;
    logic            start_nx, abort_nx;
    logic [DW_W-1:0] dwell;
    logic [TC_W-1:0] toast_cnt;
    logic            preempted;
    page_req_t       reqs;
    logic [2:0]      winner, win_rank, base_pg, issue_pg;
    logic            page_held, switch_ok, preempt;

    assign reqs = {ring_req, over_req, toast_cnt != '0, prog_req, edit_req, menu_req};

    lcd_page_prio u_prio (
        .req    (reqs),
        .winner (winner),
        .rank   (win_rank)
    );

    // A page whose own request has dropped gives way at the frame boundary.
    always_comb begin
        page_held = 1'b1;
        case (page)
            PG_RING, PG_BLANK: page_held = reqs.ring;
            PG_OVER:           page_held = reqs.over;
            PG_TOAST:          page_held = reqs.toast;
            PG_PROG:           page_held = reqs.prog;
            PG_EDIT:           page_held = reqs.edit;
            PG_MENU:           page_held = reqs.menu;
            default:           page_held = 1'b1;
        endcase
    end

    assign switch_ok = preempted || (win_rank > page_rank(page)) || !page_held
                       || (dwell >= DW_W'(MIN_DWELL));
    assign preempt   = ((winner == PG_RING) || (winner == PG_OVER))
                       && (win_rank > page_rank(page));

    always_comb begin
        base_pg = switch_ok ? winner : page;
        if (base_pg == PG_BLANK) base_pg = PG_RING;
`ifdef LCD_SCHED_BLINK_EN
        issue_pg = (base_pg == PG_RING && page == PG_RING) ? PG_BLANK : base_pg;
`else
        issue_pg = base_pg;
`endif
    end

    always_comb begin
        state_nx = state;
        start_nx = 1'b0;
        abort_nx = 1'b0;
        case (state)
            WAIT_INIT: if (init_done) state_nx = ISSUE;
            ISSUE: begin
                start_nx = 1'b1;
                state_nx = BUSY;
            end
            BUSY: begin
                // A frame that completes in the same cycle needs no abort.
                if (frame_done) begin
                    state_nx = ISSUE;
                end else if (preempt) begin
                    abort_nx = 1'b1;
                    state_nx = ABORT;
                end
            end
            ABORT:   if (frame_done) state_nx = ISSUE;
            default: state_nx = WAIT_INIT;
        endcase
    end

    // NOTE: the reset branch clears every register, including page and counters,
    // so a reset mid-frame drops the frame without any abort pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= WAIT_INIT;
            page      <= PG_CLOCK;
            start     <= 1'b0;
            abort     <= 1'b0;
            busy      <= 1'b0;
            dwell     <= '0;
            toast_cnt <= '0;
            preempted <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nx;
            start <= start_nx;
            abort <= abort_nx;

            if (state == ISSUE) begin
                page      <= issue_pg;
                busy      <= 1'b1;
                preempted <= 1'b0;
                if (!(issue_pg == page || (is_ring_group(issue_pg) && is_ring_group(page))))
                    dwell <= '0;
            end

            if ((state == BUSY || state == ABORT) && frame_done) begin
                busy <= 1'b0;
                if (dwell < DW_W'(MIN_DWELL)) dwell <= dwell + 1'b1;
            end

            if (state == BUSY && !frame_done && preempt) preempted <= 1'b1;

            // Reload rather than accumulate on a repeated commit.
            if (commit)
                toast_cnt <= TC_W'(TOAST_FRAMES);
            else if (state == BUSY && frame_done && page == PG_TOAST && toast_cnt != '0)
                toast_cnt <= toast_cnt - 1'b1;
        end
    end

endmodule

// File: tb/tb_lcd_page_sched.sv
// Directed bench for lcd_page_sched: priority, preemption, toast, blink
// (when LCD_SCHED_BLINK_EN is defined) and reset behaviour.
module tb_lcd_page_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_done, ring_req, over_req, prog_req, edit_req, menu_req;
    logic       commit, frame_done;
    logic [2:0] page;
    logic       start, abort, busy;

    int n_checks = 0;
    int n_errors = 0;

`ifdef LCD_SCHED_BLINK_EN
    localparam logic [2:0] RING_ALT = 3'd7;
`else
    localparam logic [2:0] RING_ALT = 3'd5;
`endif

    always #5 clk = ~clk;

    lcd_page_sched #(.MIN_DWELL(2), .TOAST_FRAMES(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .ring_req   (ring_req),
        .over_req   (over_req),
        .prog_req   (prog_req),
        .edit_req   (edit_req),
        .menu_req   (menu_req),
        .commit     (commit),
        .frame_done (frame_done),
        .page       (page),
        .start      (start),
        .abort      (abort),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // End the current frame and expect the next start exactly two cycles later.
    task automatic frame(input logic [2:0] exp_pg, input string tag);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check({tag, "_gap_start"}, start, 1'b0);
        check({tag, "_gap_busy"}, busy, 1'b0);
        tick();
        check({tag, "_start"}, start, 1'b1);
        check({tag, "_page"}, page, exp_pg);
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_abort"}, abort, 1'b0);
        tick();
        check({tag, "_start_pulse"}, start, 1'b0);
        tick();
    endtask

    task automatic wait_start(input int budget, input logic [2:0] exp_pg, input string tag);
        for (int i = 0; i < budget && !start; i++) tick();
        check({tag, "_start"}, start, 1'b1);
        check({tag, "_page"}, page, exp_pg);
        check({tag, "_busy"}, busy, 1'b1);
        tick();
        check({tag, "_start_pulse"}, start, 1'b0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        {init_done, ring_req, over_req, prog_req, edit_req, menu_req} = '0;
        commit = 1'b0;
        frame_done = 1'b0;
        repeat (3) tick();
        check("rst_page", page, 3'd0);
        check("rst_start", start, 1'b0);
        check("rst_abort", abort, 1'b0);
        check("rst_busy", busy, 1'b0);

        // Waiting for init: no start, stray frame_done ignored.
        rst = 1'b1;
        repeat (3) tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        repeat (3) tick();
        check("wait_init_start", start, 1'b0);
        check("wait_init_busy", busy, 1'b0);

        init_done = 1'b1;
        wait_start(6, 3'd0, "init");
        frame(3'd0, "idle_clock");

        // Higher priority takes over; dropped requests lose at the boundary.
        menu_req = 1'b1;
        frame(3'd2, "menu");
        edit_req = 1'b1;
        frame(3'd1, "edit_over_menu");
        edit_req = 1'b0;
        frame(3'd2, "edit_dropped");
        menu_req = 1'b0;
        frame(3'd0, "menu_dropped");

        // RING preempts a PROG frame with a single abort pulse.
        prog_req = 1'b1;
        frame(3'd3, "prog");
        ring_req = 1'b1;
        tick();
        check("ring_abort", abort, 1'b1);
        tick();
        check("ring_abort_pulse", abort, 1'b0);
        check("ring_abort_busy", busy, 1'b1);
        tick();
        check("ring_abort_once", abort, 1'b0);
        frame(3'd5, "ring_after_abort");
        frame(RING_ALT, "ring_2");
        frame(3'd5, "ring_3");
        frame(RING_ALT, "ring_4");

        // RING drops mid-frame: no abort, PROG returns.
        ring_req = 1'b0;
        tick();
        check("ring_drop_abort", abort, 1'b0);
        frame(3'd3, "prog_back");

        // RING rises together with frame_done: no abort.
        ring_req = 1'b1;
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check("coinc_abort", abort, 1'b0);
        tick();
        check("coinc_start", start, 1'b1);
        check("coinc_page", page, 3'd5);
        check("coinc_abort2", abort, 1'b0);
        tick();
        tick();
        ring_req = 1'b0;
        frame(3'd3, "prog_after_coinc");

        // OVER preempts PROG as well.
        over_req = 1'b1;
        tick();
        check("over_abort", abort, 1'b1);
        tick();
        frame(3'd4, "over");
        over_req = 1'b0;
        frame(3'd3, "prog_after_over");
        prog_req = 1'b0;
        frame(3'd0, "clock_again");

        // Toast: exactly four frames, then the prior winner.
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("toast_no_abort", abort, 1'b0);
        for (int i = 0; i < 4; i++) frame(3'd6, "toast_a");
        frame(3'd0, "toast_a_end");

        // Second commit after two toast frames reloads to four more.
        prog_req = 1'b1;
        frame(3'd3, "prog_toast");
        commit = 1'b1;
        tick();
        commit = 1'b0;
        frame(3'd6, "toast_b1");
        frame(3'd6, "toast_b2");
        frame(3'd6, "toast_b3");
        commit = 1'b1;
        tick();
        commit = 1'b0;
        frame(3'd6, "toast_b4");
        frame(3'd6, "toast_b5");
        frame(3'd6, "toast_b6");
        frame(3'd3, "toast_b_end");

        // Reset in the middle of a RING frame, with a toast pending.
        ring_req = 1'b1;
        tick();
        check("pre_rst_abort", abort, 1'b1);
        tick();
        frame(3'd5, "ring_pre_rst");
        commit = 1'b1;
        tick();
        commit = 1'b0;
        init_done = 1'b0;
        rst = 1'b0;
        tick();
        check("midrst_page", page, 3'd0);
        check("midrst_start", start, 1'b0);
        check("midrst_abort", abort, 1'b0);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b1;
        ring_req = 1'b0;
        repeat (4) tick();
        check("postrst_start", start, 1'b0);
        check("postrst_abort", abort, 1'b0);
        check("postrst_busy", busy, 1'b0);
        init_done = 1'b1;
        wait_start(6, 3'd3, "restart");
        frame(3'd3, "restart_prog");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
